lfsr_digit_gen: RTL
===================

LFSR_DIGIT_GEN -- requirements
Module: lfsr_digit_gen

Interface
REQ-001 Parameter SEED_DEFAULT, 16'hACE1, LFSR value loaded at reset and substituted for an all-zero seed.
REQ-002 Parameter MAX_RETRY, 8, maximum LFSR steps per request before forced output.
REQ-003 clk  input  1  global clock input; all state updates on its rising edge.
REQ-004 rst_n  input  1  active-low reset, asynchronous assertion, applied on negedge rst_n.
REQ-005 tick  input  1  slow divided-clock level from the frequency divider, same clk domain; a rising edge requests one digit.
REQ-006 en  input  1  request enable; tick edges are ignored while low.
REQ-007 seed_load  input  1  single-cycle strobe that loads seed.
REQ-008 seed  input  16  seed value.
REQ-009 rnd_digit  output  4  last accepted random digit, 0..9.
REQ-010 rnd_valid  output  1  one-cycle pulse when rnd_digit updates.
REQ-011 busy  output  1  high while state is STEP.
REQ-012 overrun  output  1  sticky flag: a request edge arrived while busy.
REQ-013 lfsr  output  16  current LFSR state, for debug.

Function
REQ-014 The block SHALL register tick every cycle as tick_d; a request edge is tick=1 and tick_d=0 at a clock edge, qualified by en=1.
REQ-015 The LFSR step SHALL be Fibonacci: fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; lfsr <= {lfsr[14:0], fb}.
REQ-016 The state machine SHALL have two states: IDLE and STEP.
REQ-017 IDLE: on a request edge, lfsr steps once, retry count is set to 1, and the state goes to STEP; otherwise lfsr holds.
REQ-018 STEP: if lfsr[3:0] < 10, rnd_digit <= lfsr[3:0], rnd_valid <= 1 for one cycle, and the state returns to IDLE, with no LFSR step.
REQ-019 STEP: else if retry count < MAX_RETRY, lfsr steps, retry count increments, and the state stays in STEP.
REQ-020 STEP: else (retry count = MAX_RETRY), rnd_digit <= lfsr[3:0] - 10, rnd_valid pulses, and the state returns to IDLE.
REQ-021 Latency: if a request edge is sampled at clock edge k and the first nibble is accepted, rnd_valid SHALL be high in the cycle after edge k+1; each rejection SHALL add one cycle.
REQ-022 A request edge while in STEP SHALL be dropped and SHALL set overrun; overrun SHALL clear only on seed_load or reset.
REQ-023 seed_load SHALL have priority over all other activity:
- lfsr <= (seed==0 ? SEED_DEFAULT : seed);
- state <= IDLE;
- any in-progress request is aborted with no rnd_valid;
- overrun <= 0.
REQ-024 seed_load coincident with a request edge SHALL load the seed and discard the request.
REQ-025 The LFSR SHALL never hold 16'h0000.
REQ-026 rnd_digit SHALL hold its value between valid pulses.
REQ-027 A deasserted en SHALL NOT abort an in-progress STEP.

Reset
REQ-028 When rst_n=0, the block SHALL immediately set:
- lfsr = SEED_DEFAULT;
- rnd_digit = 0, rnd_valid = 0;
- busy = 0, overrun = 0;
- tick_d = 0, retry = 0, state = IDLE.
REQ-029 After rst_n deasserts, tick already high SHALL count as a request edge on the first clock.
REQ-030 Reset asserted mid-STEP SHALL abort the request with no rnd_valid.

Verification
REQ-031 Reset, en=1, tick 0->1 -> lfsr=16'h59C3, rnd_digit=3, rnd_valid pulses once.
REQ-032 seed_load with seed=16'h0007, then a tick edge -> lfsr goes 000E, 001C, 0038; rnd_digit=8 after 2 rejections; rnd_valid pulses 3 cycles after the edge-sample cycle.
REQ-033 seed_load with seed=16'h0000 -> lfsr=16'hACE1; a following tick edge -> rnd_digit=3.
REQ-034 With seed 16'h0007, a second tick edge during STEP -> overrun=1, only one rnd_valid; then seed_load -> overrun=0.
REQ-035 en=0 with a tick edge -> lfsr unchanged, no rnd_valid, busy stays 0.
REQ-036 rst_n pulsed low during STEP -> all outputs at reset values immediately, no rnd_valid afterwards.

Source files
------------

// File: rtl/lfsr_digit_gen.sv
// Random decimal digit generator: a 16-bit Fibonacci LFSR is stepped on each tick request
// until its low nibble is a valid digit, with a bounded retry count and a forced fold-down.
module lfsr_digit_gen #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int unsigned MAX_RETRY    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        en,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [3:0]  rnd_digit,
  output logic        rnd_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] lfsr
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [0:0] {StIdle, StStep} state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [3:0]        digit_q, digit_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              tick_q;
  logic              req;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // tick_q resets to 0, so a tick already high at reset release counts as an edge.
  assign req = tick & ~tick_q & en;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    retry_d   = retry_q;
    digit_d   = digit_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (seed_load) begin
      // An all-zero seed would lock the LFSR, so fall back to the default.
      lfsr_d    = (seed == 16'h0000) ? SEED_DEFAULT : seed;
      state_d   = StIdle;
      retry_d   = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            lfsr_d  = lfsr_step(lfsr_q);
            retry_d = RetryW'(1);
            state_d = StStep;
          end
        end
        StStep: begin
          if (req) begin
            overrun_d = 1'b1;
          end
          if (lfsr_q[3:0] < 4'd10) begin
            digit_d = lfsr_q[3:0];
            valid_d = 1'b1;
            state_d = StIdle;
          end else if (retry_q < RetryMax) begin
            lfsr_d  = lfsr_step(lfsr_q);
            retry_d = retry_q + RetryW'(1);
          end else begin
            digit_d = lfsr_q[3:0] - 4'd10;
            valid_d = 1'b1;
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED_DEFAULT;
      retry_q   <= '0;
      digit_q   <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      retry_q   <= retry_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      tick_q    <= tick;
    end
  end

  assign rnd_digit = digit_q;
  assign rnd_valid = valid_q;
  assign busy      = (state_q == StStep);
  assign overrun   = overrun_q;
  assign lfsr      = lfsr_q;

endmodule
